periph_bus_master: RTL and testbench

PERIPH_BUS_MASTER -- requirements
Module: periph_bus_master

---
 rtl/periph_bus_master.sv | 162 ++++++++++++++++
 tb/tb_periph_bus_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_master.sv
// CPU-side master for a 16-byte peripheral register window with ce-qualified
// read/write strobes, byte-lane read-modify-write and a strobe timeout.
module periph_bus_master #(
  parameter logic [15:0] BASE    = 16'o177700,
  parameter int          TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  bsel,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  input  logic        ce,
  output logic        regrd,
  output logic        regwr,
  output logic [3:0]  paddr,
  output logic [15:0] pdata_o,
  input  logic [15:0] pdata_i
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_STB  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_RD_CAP  = 3'd3;
  localparam logic [2:0] S_MERGE   = 3'd4;
  localparam logic [2:0] S_WR_STB  = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   hold_q, hold_d;
  logic [3:0]    paddr_q, paddr_d;
  logic [15:0]   pdata_q, pdata_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    bsel_q, bsel_d;
  logic          rmw_q, rmw_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    wdata_d = wdata_q;
    bsel_d  = bsel_q;
    rmw_d   = rmw_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          err_d = 1'b0;
          rmw_d = 1'b0;
          // Out-of-window takes priority over an empty lane mask.
          if (addr[15:4] != BASE[15:4]) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (bsel == 2'b00) begin
            state_d = S_RESP;
          end else begin
            paddr_d = addr[3:0] & 4'b1110;
            bsel_d  = bsel;
            wdata_d = wdata;
            cnt_d   = '0;
            if (!we) begin
              state_d = S_RD_STB;
            end else if (bsel == 2'b11) begin
              pdata_d = wdata;
              state_d = S_WR_STB;
            end else begin
              rmw_d   = 1'b1;
              state_d = S_RD_STB;
            end
          end
        end
      end

      S_RD_STB: begin
        if (ce) begin
          state_d = S_RD_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // The peripheral registers its read data in the ce cycle; give it a beat.
      S_RD_WAIT: state_d = S_RD_CAP;

      S_RD_CAP: begin
        hold_d  = pdata_i;
        state_d = rmw_q ? S_MERGE : S_RESP;
      end

      S_MERGE: begin
        pdata_d = {bsel_q[1] ? wdata_q[15:8] : hold_q[15:8],
                   bsel_q[0] ? wdata_q[7:0]  : hold_q[7:0]};
        cnt_d   = '0;
        state_d = S_WR_STB;
      end

      S_WR_STB: begin
        if (ce) begin
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      paddr_q <= '0;
      pdata_q <= '0;
      wdata_q <= '0;
      bsel_q  <= '0;
      rmw_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      wdata_q <= wdata_d;
      bsel_q  <= bsel_d;
      rmw_q   <= rmw_d;
      err_q   <= err_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign ack     = (state_q == S_RESP);
  assign err     = ack & err_q;
  assign regrd   = (state_q == S_RD_STB);
  assign regwr   = (state_q == S_WR_STB);
  assign paddr   = paddr_q;
  assign pdata_o = pdata_q;
  assign rdata   = hold_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Self-checking bench: vector table of single accesses plus hand-written
// sequences for held req and reset during a read-modify-write.
module tb_periph_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  bsel = 2'b00;
  logic [15:0] addr = 16'h0;
  logic [15:0] wdata = 16'h0;
  logic        busy, ack, err;
  logic [15:0] rdata;
  logic        ce = 1'b1;
  logic        regrd, regwr;
  logic [3:0]  paddr;
  logic [15:0] pdata_o;
  logic [15:0] pdata_i = 16'h0;

  periph_bus_master dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .bsel(bsel), .addr(addr),
    .wdata(wdata), .busy(busy), .ack(ack), .err(err), .rdata(rdata), .ce(ce),
    .regrd(regrd), .regwr(regwr), .paddr(paddr), .pdata_o(pdata_o),
    .pdata_i(pdata_i)
  );

  always #5 clk = ~clk;

  // Peripheral model: eight word registers, acts only on ce-qualified strobes.
  logic [15:0] regs [0:7] = '{16'h1000, 16'h1101, 16'h1202, 16'h1303,
                              16'o001234, 16'hFF11, 16'h1606, 16'h1707};
  int nrd_cnt = 0, nwr_cnt = 0, rdhi_cnt = 0, wrhi_cnt = 0, overlap_cnt = 0;

  always @(posedge clk) begin
    if (regrd) rdhi_cnt <= rdhi_cnt + 1;
    if (regwr) wrhi_cnt <= wrhi_cnt + 1;
    if (regrd && regwr) overlap_cnt <= overlap_cnt + 1;
    if (ce && regrd) begin
      pdata_i <= regs[paddr[3:1]];
      nrd_cnt <= nrd_cnt + 1;
    end
    if (ce && regwr) begin
      regs[paddr[3:1]] <= pdata_o;
      nwr_cnt <= nwr_cnt + 1;
    end
  end

  // ce pattern: 0 = held low, 1 = tied high, N = high every Nth cycle.
  int ce_period = 1;
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (ce_period == 1)      ce = 1'b1;
    else if (ce_period == 0) ce = 1'b0;
    else                     ce = ((cyc % ce_period) == 0);
  end

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [15:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        we;
    logic [1:0]  bsel;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          ce_period;
    logic        exp_err;
    logic        chk_rd;
    logic [15:0] exp_rdata;
    int          exp_lat;   // negedges after the accepting edge; -1 = skip
    int          exp_nrd;
    int          exp_nwr;
    int          exp_rdhi;  // regrd-high cycles; -1 = skip
    int          exp_wrhi;
    logic        chk_reg;
    logic [15:0] exp_reg;
  } vec_t;
  vec_t vecs [12];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Wait for ack, then pop the scoreboard and compare the response.
  task automatic wait_ack(output int lat);
    exp_t e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack && lat < 300);
    check("ack_seen", {31'd0, ack}, 32'd1);
    if (ack) begin
      if (sb_q.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("resp_err", {31'd0, err}, {31'd0, e.err});
        if (e.chk_rd) check("resp_rdata", {16'd0, rdata}, {16'd0, e.rdata});
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat, nrd0, nwr0, rdhi0, wrhi0;
    ce_period = v.ce_period;
    @(negedge clk);
    nrd0 = nrd_cnt; nwr0 = nwr_cnt; rdhi0 = rdhi_cnt; wrhi0 = wrhi_cnt;
    req = 1'b1; we = v.we; bsel = v.bsel; addr = v.addr; wdata = v.wdata;
    sb_q.push_back('{v.exp_err, v.chk_rd, v.exp_rdata});
    @(posedge clk);
    #1 req = 1'b0;
    wait_ack(lat);
    $display("vec %0d: we=%0b bsel=%b addr=%o lat=%0d err=%0b rdata=%h", idx, v.we, v.bsel,
             v.addr, lat, err, rdata);
    if (v.exp_lat >= 0)  check("latency", lat, v.exp_lat);
    check("reads", nrd_cnt - nrd0, v.exp_nrd);
    check("writes", nwr_cnt - nwr0, v.exp_nwr);
    if (v.exp_rdhi >= 0) check("regrd_cycles", rdhi_cnt - rdhi0, v.exp_rdhi);
    if (v.exp_wrhi >= 0) check("regwr_cycles", wrhi_cnt - wrhi0, v.exp_wrhi);
    if (v.chk_reg) check("periph_reg", {16'd0, regs[v.addr[3:1]]}, {16'd0, v.exp_reg});
    @(negedge clk);
    check("idle_after_resp", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int k, nwr0;
    vecs[0]  = '{1'b0, 2'b11, 16'o177710, 16'h0000, 1, 1'b0, 1'b1, 16'o001234, 4, 1, 0, 1, 0, 1'b0, 16'h0};
    vecs[1]  = '{1'b1, 2'b11, 16'o177706, 16'o000500, 4, 1'b0, 1'b0, 16'h0, -1, 0, 1, 0, -1, 1'b1, 16'o000500};
    vecs[2]  = '{1'b1, 2'b10, 16'o177712, 16'hAB00, 1, 1'b0, 1'b0, 16'h0, 6, 1, 1, 1, 1, 1'b1, 16'hAB11};
    vecs[3]  = '{1'b0, 2'b11, 16'o177600, 16'h0000, 1, 1'b1, 1'b0, 16'h0, 1, 0, 0, 0, 0, 1'b0, 16'h0};
    vecs[4]  = '{1'b0, 2'b11, 16'o177704, 16'h0000, 0, 1'b1, 1'b0, 16'h0, 65, 0, 0, 64, 0, 1'b0, 16'h0};
    vecs[5]  = '{1'b1, 2'b00, 16'o177702, 16'h1234, 1, 1'b0, 1'b0, 16'h0, 1, 0, 0, 0, 0, 1'b1, 16'h1101};
    vecs[6]  = '{1'b1, 2'b01, 16'o177712, 16'h5577, 1, 1'b0, 1'b0, 16'h0, 6, 1, 1, 1, 1, 1'b1, 16'hAB77};
    vecs[7]  = '{1'b0, 2'b11, 16'o177712, 16'h0000, 4, 1'b0, 1'b1, 16'hAB77, -1, 1, 0, -1, 0, 1'b0, 16'h0};
    vecs[8]  = '{1'b1, 2'b11, 16'o177714, 16'hBEEF, 0, 1'b1, 1'b0, 16'h0, 65, 0, 0, 0, 64, 1'b1, 16'h1606};
    vecs[9]  = '{1'b0, 2'b11, 16'o177700, 16'h0000, 1, 1'b0, 1'b1, 16'h1000, 4, 1, 0, 1, 0, 1'b0, 16'h0};
    vecs[10] = '{1'b0, 2'b11, 16'o177713, 16'h0000, 1, 1'b0, 1'b1, 16'hAB77, 4, 1, 0, 1, 0, 1'b0, 16'h0};
    vecs[11] = '{1'b0, 2'b01, 16'o177716, 16'h0000, 1, 1'b0, 1'b1, 16'h1707, 4, 1, 0, 1, 0, 1'b0, 16'h0};

    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_ack",   {31'd0, ack},   32'd0);
    check("rst_err",   {31'd0, err},   32'd0);
    check("rst_regrd", {31'd0, regrd}, 32'd0);
    check("rst_regwr", {31'd0, regwr}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_pdata", {16'd0, pdata_o}, 32'd0);
    check("rst_paddr", {28'd0, paddr}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // req held high: second access accepted only in the IDLE cycle after RESP.
    ce_period = 1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; bsel = 2'b11; addr = 16'o177710;
    sb_q.push_back('{1'b0, 1'b1, 16'o001234});
    sb_q.push_back('{1'b0, 1'b1, 16'o001234});
    @(posedge clk);
    for (k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("held_ack", {31'd0, ack}, {31'd0, (k == 4 || k == 9)});
      if (ack && sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("held_rdata", {16'd0, rdata}, {16'd0, e.rdata});
        $display("held req: ack at cycle %0d rdata=%h", k, rdata);
      end
      if (k == 5) check("held_idle", {31'd0, busy}, 32'd0);
      if (k == 6) req = 1'b0;
    end

    // Reset while an RMW write strobe waits on ce: no write, no ack.
    ce_period = 1;
    @(negedge clk);
    req = 1'b1; we = 1'b1; bsel = 2'b01; addr = 16'o177712; wdata = 16'h0011;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ce_period = 0;
    k = 0;
    while (!regwr && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rmw_reached_wr", {31'd0, regwr}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    nwr0 = nwr_cnt;
    reset = 1'b1;
    @(negedge clk);
    $display("reset during RMW: regwr=%0b busy=%0b ack=%0b", regwr, busy, ack);
    check("rmw_rst_regwr", {31'd0, regwr}, 32'd0);
    check("rmw_rst_busy",  {31'd0, busy},  32'd0);
    check("rmw_rst_ack",   {31'd0, ack},   32'd0);
    check("rmw_rst_pdata", {16'd0, pdata_o}, 32'd0);
    check("rmw_rst_rdata", {16'd0, rdata}, 32'd0);
    reset = 1'b0;
    ce_period = 1;
    for (k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rmw_no_ack", {31'd0, ack}, 32'd0);
    end
    check("rmw_no_write", nwr_cnt - nwr0, 0);
    check("rmw_reg_kept", {16'd0, regs[5]}, {16'd0, 16'hAB77});

    check("strobe_overlap", overlap_cnt, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
